// File: rtl/sim_monitor.sv
// Simulation-side register-file monitor: shadows watched registers, queues value-change
// events in a FWFT FIFO, and decides PASS/FAIL/TIMEOUT from the done/pass registers.
module sim_monitor #(
    parameter int XLEN       = 64,
    parameter int NUM_WATCH  = 3,
    parameter int WATCH_BASE = 27,
    parameter int DONE_REG   = 26,
    parameter int PASS_REG   = 27,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 100000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_en,
    input  logic [4:0]                wb_addr,
    input  logic [XLEN-1:0]           wb_data,
    output logic [NUM_WATCH*XLEN-1:0] watch_val,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [2:0]                ev_idx,
    output logic [XLEN-1:0]           ev_data,
    output logic                      ev_overflow,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [2:0]                state,
    output logic                      done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               ENTRY_W = 3 + XLEN;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [XLEN-1:0]  ONE_VAL = {{(XLEN-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_nextState;
    logic [XLEN-1:0]      r_shadow [NUM_WATCH];
    logic [XLEN-1:0]      r_passShadow;
    logic [ENTRY_W-1:0]   r_fifo [FIFO_DEPTH];
    logic [PTR_W:0]       r_wrPtr;
    logic [PTR_W:0]       r_rdPtr;
    logic                 r_overflow;
    logic [CNT_W-1:0]     r_cycleCnt;

    logic                 w_accept;
    logic                 w_watchHit;
    logic [2:0]           w_slot;
    logic [XLEN-1:0]      w_oldVal;
    logic                 w_change;
    logic                 w_doneWr;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    assign w_accept   = (r_state == ST_RUN) && wb_en && (wb_addr != 5'd0);
    assign w_watchHit = w_accept
                        && ({1'b0, wb_addr} >= 6'(WATCH_BASE))
                        && ({1'b0, wb_addr} <  6'(WATCH_BASE + NUM_WATCH));
    assign w_slot     = 3'(wb_addr - 5'(WATCH_BASE));
    assign w_doneWr   = w_accept && (wb_addr == 5'(DONE_REG)) && (wb_data == ONE_VAL);

    always_comb begin
        w_oldVal = '0;
        for (int i = 0; i < NUM_WATCH; i++) begin
            if (w_slot == 3'(i)) begin
                w_oldVal = r_shadow[i];
            end
        end
    end

    // Only a real value change produces an event; equal rewrites are invisible
    assign w_change = w_watchHit && (w_oldVal != wb_data);

    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W])
                     && (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
    assign w_pop   = !w_empty && ev_ready;
    assign w_push  = w_change && (!w_full || w_pop);
    assign w_drop  = w_change && w_full && !w_pop;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: w_nextState = ST_RUN;
            ST_RUN: begin
                if (w_doneWr) begin
                    w_nextState = (r_passShadow == ONE_VAL) ? ST_PASS : ST_FAIL;
                end else if (r_cycleCnt == TO_LAST) begin
                    w_nextState = ST_TIMEOUT;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: w_nextState = r_state;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The counter stops on the edge that leaves RUN, so it shows the last RUN count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycleCnt <= '0;
        end else if ((r_state == ST_RUN) && (w_nextState == ST_RUN) && (r_cycleCnt != '1)) begin
            r_cycleCnt <= r_cycleCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WATCH; i++) begin
                r_shadow[i] <= '0;
            end
            r_passShadow <= '0;
        end else begin
            for (int i = 0; i < NUM_WATCH; i++) begin
                if (w_change && (w_slot == 3'(i))) begin
                    r_shadow[i] <= wb_data;
                end
            end
            if (w_accept && (wb_addr == 5'(PASS_REG))) begin
                r_passShadow <= wb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wrPtr[PTR_W-1:0]] <= {w_slot, wb_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + (PTR_W+1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_WATCH; g++) begin : g_watch
            assign watch_val[g*XLEN +: XLEN] = r_shadow[g];
        end
    endgenerate

    assign ev_valid          = !w_empty;
    assign {ev_idx, ev_data} = r_fifo[r_rdPtr[PTR_W-1:0]];
    assign ev_overflow       = r_overflow;
    assign cycle_cnt         = r_cycleCnt;
    assign state             = r_state;
    assign done              = (r_state == ST_PASS) || (r_state == ST_FAIL) || (r_state == ST_TIMEOUT);

endmodule

// File: tb/tb_sim_monitor.sv
// Scoreboard bench for sim_monitor: stimulus queues expected events, a negedge
// monitor compares every consumed event; a second short-timeout instance covers TIMEOUT.
module tb_sim_monitor;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wb_en = 1'b0;
    logic [4:0]   wb_addr = 5'd0;
    logic [63:0]  wb_data = 64'd0;
    logic [191:0] watch_val;
    logic         ev_valid;
    logic         ev_ready = 1'b1;
    logic [2:0]   ev_idx;
    logic [63:0]  ev_data;
    logic         ev_overflow;
    logic [31:0]  cycle_cnt;
    logic [2:0]   state;
    logic         done;

    logic         toWbEn = 1'b0;
    logic         toEvReady = 1'b1;
    logic [191:0] toWatch;
    logic         toEvValid;
    logic [2:0]   toEvIdx;
    logic [63:0]  toEvData;
    logic         toOverflow;
    logic [31:0]  toCnt;
    logic [2:0]   toState;
    logic         toDone;

    logic [66:0]  expQ[$];
    int           checkCnt = 0;
    int           passCnt = 0;
    int           evSeen = 0;

    always #5 clk = ~clk;

    sim_monitor dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .watch_val(watch_val), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_idx(ev_idx), .ev_data(ev_data), .ev_overflow(ev_overflow),
        .cycle_cnt(cycle_cnt), .state(state), .done(done)
    );

    sim_monitor #(.TIMEOUT(16)) dutTo (
        .clk(clk), .rst(rst), .wb_en(toWbEn), .wb_addr(wb_addr), .wb_data(wb_data),
        .watch_val(toWatch), .ev_valid(toEvValid), .ev_ready(toEvReady),
        .ev_idx(toEvIdx), .ev_data(toEvData), .ev_overflow(toOverflow),
        .cycle_cnt(toCnt), .state(toState), .done(toDone)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCnt++;
        if (actual === expected) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Called at posedge+1; the write is sampled on the next rising edge
    task automatic applyStimulus(input logic [4:0] addr, input logic [63:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        @(posedge clk);
        #1;
        wb_en   = 1'b0;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wb_en = 1'b0;
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && ev_valid && ev_ready) begin
            evSeen++;
            checkCnt++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL unexpected_event: got idx=%0d data=%0h, required no event", ev_idx, ev_data);
            end else begin
                logic [66:0] expEv;
                expEv = expQ.pop_front();
                if ({ev_idx, ev_data} === expEv) begin
                    passCnt++;
                end else begin
                    $display("[TB] FAIL event: got idx=%0d data=%0h, required idx=%0d data=%0h",
                             ev_idx, ev_data, expEv[66:64], expEv[63:0]);
                end
            end
        end
    end

    initial begin
        #12;
        checkOutput("reset_state", {61'd0, state}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_ev_valid", {63'd0, ev_valid}, 64'd0);
        checkOutput("reset_watch_slot1", watch_val[64 +: 64], 64'd0);
        checkOutput("reset_cycle_cnt", {32'd0, cycle_cnt}, 64'd0);

        // Equal-value rewrite must not create a second event
        applyReset();
        ev_ready = 1'b1;
        evSeen   = 0;
        checkOutput("run_after_reset", {61'd0, state}, 64'd1);
        expQ.push_back({3'd1, 64'd5});
        applyStimulus(5'd28, 64'd5);
        applyStimulus(5'd28, 64'd5);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("s1_slot1", watch_val[64 +: 64], 64'd5);
        checkOutput("s1_event_count", 64'(evSeen), 64'd1);
        checkOutput("s1_ev_valid", {63'd0, ev_valid}, 64'd0);

        applyReset();
        expQ.push_back({3'd0, 64'd1});
        applyStimulus(5'd27, 64'd1);
        applyStimulus(5'd26, 64'd1);
        checkOutput("s2_state_pass", {61'd0, state}, 64'd2);
        checkOutput("s2_done", {63'd0, done}, 64'd1);
        checkOutput("s2_cnt", {32'd0, cycle_cnt}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("s2_cnt_frozen", {32'd0, cycle_cnt}, 64'd1);
        checkOutput("s2_state_hold", {61'd0, state}, 64'd2);

        applyReset();
        applyStimulus(5'd26, 64'd1);
        checkOutput("s3_state_fail", {61'd0, state}, 64'd3);
        applyStimulus(5'd28, 64'd7);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("s3_slot1_ignored", watch_val[64 +: 64], 64'd0);
        checkOutput("s3_ev_valid", {63'd0, ev_valid}, 64'd0);
        checkOutput("s3_done", {63'd0, done}, 64'd1);

        // Short-timeout instance: 16 RUN cycles then TIMEOUT with count 15
        applyReset();
        checkOutput("to_first_run", {61'd0, toState}, 64'd1);
        checkOutput("to_first_cnt", {32'd0, toCnt}, 64'd0);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("to_last_run", {61'd0, toState}, 64'd1);
        checkOutput("to_last_cnt", {32'd0, toCnt}, 64'd15);
        @(posedge clk);
        #1;
        checkOutput("to_state", {61'd0, toState}, 64'd4);
        checkOutput("to_cnt", {32'd0, toCnt}, 64'd15);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("to_cnt_frozen", {32'd0, toCnt}, 64'd15);
        checkOutput("to_done", {63'd0, toDone}, 64'd1);

        // Fill the FIFO, overflow it, then push+pop while full and drain
        applyReset();
        ev_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expQ.push_back({3'(i % 3), 64'h10 + 64'(i)});
            applyStimulus(5'd27 + 5'(i % 3), 64'h10 + 64'(i));
        end
        checkOutput("s5_no_overflow_at_full", {63'd0, ev_overflow}, 64'd0);
        checkOutput("s5_ev_valid_full", {63'd0, ev_valid}, 64'd1);
        applyStimulus(5'd29, 64'h18);
        checkOutput("s5_overflow", {63'd0, ev_overflow}, 64'd1);
        checkOutput("s5_slot2_updated", watch_val[128 +: 64], 64'h18);
        ev_ready = 1'b1;
        expQ.push_back({3'd1, 64'h99});
        applyStimulus(5'd28, 64'h99);
        begin
            int budget;
            budget = 0;
            while ((expQ.size() != 0 || ev_valid) && budget < 40) begin
                @(posedge clk);
                #1;
                budget++;
            end
            if (budget >= 40) begin
                checkCnt++;
                $display("[TB] FAIL drain_timeout: got %0d events left, required 0", expQ.size());
            end
        end
        checkOutput("s5_drained", {63'd0, ev_valid}, 64'd0);
        checkOutput("s5_overflow_sticky", {63'd0, ev_overflow}, 64'd1);
        checkOutput("s5_slot1", watch_val[64 +: 64], 64'h99);
        checkOutput("s5_slot0", watch_val[0 +: 64], 64'h16);

        // Asynchronous reset with events still queued
        applyReset();
        ev_ready = 1'b0;
        applyStimulus(5'd27, 64'd1);
        applyStimulus(5'd28, 64'd2);
        applyStimulus(5'd29, 64'd3);
        checkOutput("s6_ev_valid_queued", {63'd0, ev_valid}, 64'd1);
        rst = 1'b0;
        expQ.delete();
        #1;
        checkOutput("s6_ev_valid", {63'd0, ev_valid}, 64'd0);
        checkOutput("s6_state", {61'd0, state}, 64'd0);
        checkOutput("s6_slot0", watch_val[0 +: 64], 64'd0);
        checkOutput("s6_slot2", watch_val[128 +: 64], 64'd0);
        checkOutput("s6_cnt", {32'd0, cycle_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
